// File: rtl/serialize_pkg.sv
// rtl/serialize_pkg.sv - shared constants and width helper for serialize_arb
package serialize_pkg;

  localparam int MODE_RR     = 0;
  localparam int MODE_PRI    = 1;
  localparam int MODE_GATHER = 2;

  // Width of the channel index carried in each result word.
  function automatic int selw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - 2-entry stb/rdy FIFO, full flag and outputs from registers only
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_stb,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_stb,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic         push, pop;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_stb = (cnt_q != 2'd0);
  assign out_dat = head_q;

  always_comb begin
    push   = in_stb & in_rdy;
    pop    = out_stb & out_rdy;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    // Pop first, then push into whichever slot is the new end of the queue.
    if (pop) begin
      head_d = tail_q;
      cnt_d  = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) head_d = in_dat;
      else               tail_d = in_dat;
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: rtl/serialize_arb.sv
// rtl/serialize_arb.sv - N-to-1 tagged argument serializer with RR/PRI/GATHER arbitration
module serialize_arb
  import serialize_pkg::*;
#(
  parameter int ARGW = 16,
  parameter int ARGN = 2,
  parameter int MODE = MODE_RR
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ARGN-1:0]             arg_stb,
  input  logic [ARGN*ARGW-1:0]        arg_dat,
  output logic [ARGN-1:0]             arg_rdy,
  output logic                        res_stb,
  output logic [selw(ARGN)+ARGW-1:0]  res_dat,
  output logic                        res_lst,
  input  logic                        res_rdy
);

  localparam int SELW = selw(ARGN);
  localparam int FW   = 1 + SELW + ARGW;

  logic [ARGN-1:0] msk_q, msk_d, elig, grant;
  logic [SELW-1:0] ptr_q, ptr_d, sel;
  logic            any_g, fifo_rdy, accept, lst;
  logic [FW-1:0]   fifo_in, fifo_out;

  always_comb begin
    elig  = (MODE == MODE_GATHER) ? (arg_stb & ~msk_q) : arg_stb;
    any_g = 1'b0;
    sel   = '0;
    if (MODE == MODE_RR) begin
      // Modulo on the index keeps the wrap inside 0..ARGN-1 for non-power-of-2 ARGN.
      for (int k = 1; k <= ARGN; k++) begin
        if (!any_g && elig[SELW'((int'(ptr_q) + k) % ARGN)]) begin
          any_g = 1'b1;
          sel   = SELW'((int'(ptr_q) + k) % ARGN);
        end
      end
    end else begin
      for (int i = ARGN - 1; i >= 0; i--) begin
        if (elig[SELW'(i)]) begin
          any_g = 1'b1;
          sel   = SELW'(i);
        end
      end
    end
    grant   = any_g ? (ARGN'(1) << sel) : '0;
    arg_rdy = fifo_rdy ? grant : '0;
    accept  = any_g & fifo_rdy;
    lst     = (MODE == MODE_GATHER) && ((msk_q | grant) == '1);
    fifo_in = {lst, sel, arg_dat[int'(sel)*ARGW +: ARGW]};

    msk_d = msk_q;
    ptr_d = ptr_q;
    if (accept) begin
      if (MODE == MODE_RR) ptr_d = sel;
      if (MODE == MODE_GATHER) msk_d = lst ? '0 : (msk_q | grant);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msk_q <= '0;
      ptr_q <= SELW'(ARGN - 1);
    end else begin
      msk_q <= msk_d;
      ptr_q <= ptr_d;
    end
  end

  skid_fifo2 #(.W(FW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_stb  (accept),
    .in_dat  (fifo_in),
    .in_rdy  (fifo_rdy),
    .out_stb (res_stb),
    .out_dat (fifo_out),
    .out_rdy (res_rdy)
  );

  assign res_lst = res_stb & fifo_out[FW-1];
  assign res_dat = fifo_out[FW-2:0];

endmodule

// File: tb/tb_serialize_arb.sv
// tb/tb_serialize_arb.sv - randomized self-checking bench for serialize_arb in all three modes
module tb_serialize_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // d=0: PRI ARGN=4; d=1: RR ARGN=3; d=2: GATHER ARGN=3; all ARGW=8
  logic [3:0]  p_stb, p_ardy;
  logic [31:0] p_dat;
  logic        p_rstb, p_rlst, p_rrdy;
  logic [9:0]  p_rdat;
  logic [2:0]  r_stb, r_ardy, g_stb, g_ardy;
  logic [23:0] r_dat, g_dat;
  logic        r_rstb, r_rlst, r_rrdy, g_rstb, g_rlst, g_rrdy;
  logic [9:0]  r_rdat, g_rdat;

  serialize_arb #(.ARGW(8), .ARGN(4), .MODE(1)) u_pri (
    .clk(clk), .rst(rst), .arg_stb(p_stb), .arg_dat(p_dat), .arg_rdy(p_ardy),
    .res_stb(p_rstb), .res_dat(p_rdat), .res_lst(p_rlst), .res_rdy(p_rrdy));
  serialize_arb #(.ARGW(8), .ARGN(3), .MODE(0)) u_rr (
    .clk(clk), .rst(rst), .arg_stb(r_stb), .arg_dat(r_dat), .arg_rdy(r_ardy),
    .res_stb(r_rstb), .res_dat(r_rdat), .res_lst(r_rlst), .res_rdy(r_rrdy));
  serialize_arb #(.ARGW(8), .ARGN(3), .MODE(2)) u_gat (
    .clk(clk), .rst(rst), .arg_stb(g_stb), .arg_dat(g_dat), .arg_rdy(g_ardy),
    .res_stb(g_rstb), .res_dat(g_rdat), .res_lst(g_rlst), .res_rdy(g_rrdy));

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model: words in flight as a queue of {lst, sel[1:0], dat[7:0]}
  logic [10:0] mq[$];
  int          m_ptr;
  logic [3:0]  m_msk;

  // Observed/expected vectors: {arg_rdy[3:0], res_stb, res_lst, res_dat (zero when no stb)}
  logic [15:0] obs_v, exp_v;

  task automatic cyc(input int d, input logic [3:0] stb, input logic rdy, input logic do_rst);
    logic [31:0] dat;
    logic [3:0]  elig, e_rdy, ardy;
    logic [9:0]  odat;
    logic        ostb, olst, lst;
    int          n, g, i;
    dat = $urandom;
    n = (d == 0) ? 4 : 3;
    p_stb = '0; r_stb = '0; g_stb = '0;
    p_rrdy = 1'b1; r_rrdy = 1'b1; g_rrdy = 1'b1;
    p_dat = $urandom; r_dat = dat[23:0]; g_dat = dat[23:0];
    rst = do_rst;
    case (d)
      0: begin p_stb = stb; p_dat = dat; p_rrdy = rdy; end
      1: begin r_stb = stb[2:0]; r_rrdy = rdy; end
      default: begin g_stb = stb[2:0]; g_rrdy = rdy; end
    endcase
    #1;
    case (d)
      0: begin ardy = p_ardy; ostb = p_rstb; olst = p_rlst; odat = p_rdat; end
      1: begin ardy = {1'b0, r_ardy}; ostb = r_rstb; olst = r_rlst; odat = r_rdat; end
      default: begin ardy = {1'b0, g_ardy}; ostb = g_rstb; olst = g_rlst; odat = g_rdat; end
    endcase
    obs_v = {ardy, ostb, olst, ostb ? odat : 10'd0};

    elig = stb & ((d == 2) ? ~m_msk : 4'hF) & 4'((1 << n) - 1);
    g = -1;
    if (d == 1) begin
      for (int k = 1; k <= n; k++) begin
        i = (m_ptr + k) % n;
        if (g < 0 && elig[i]) g = i;
      end
    end else begin
      for (int k = n - 1; k >= 0; k--) if (elig[k]) g = k;
    end
    e_rdy = (g >= 0 && mq.size() < 2) ? 4'(1 << g) : 4'd0;
    exp_v = {e_rdy, mq.size() > 0, (mq.size() > 0) ? mq[0] : 11'd0};

    if (do_rst) begin
      mq.delete();
      m_ptr = n - 1;
      m_msk = '0;
    end else begin
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (e_rdy != 0) begin
        lst = (d == 2) && ((m_msk | 4'(1 << g)) == 4'((1 << n) - 1));
        mq.push_back({lst, 2'(g), dat[g*8 +: 8]});
        if (d == 1) m_ptr = g;
        if (d == 2) m_msk = lst ? 4'd0 : (m_msk | 4'(1 << g));
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic do_reset(input int d);
    cyc(d, 4'd0, 1'b1, 1'b1);
    cyc(d, 4'd0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      do_reset(d);
      cyc(d, 4'hF, 1'b0, 1'b0);
      checks++;
      if (obs_v !== exp_v || obs_v !== 16'h1000) begin
        errors++;
        $display("FAIL reset d=%0d got=%h exp=%h", d, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_pri();
    do_reset(0);
    for (int c = 0; c < 80; c++) begin
      if (c < 20) cyc(0, 4'b1010, 1'b1, 1'b0);
      else        cyc(0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL pri c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_rr();
    do_reset(1);
    for (int c = 0; c < 90; c++) begin
      if (c < 12) cyc(1, 4'hF, 1'b1, 1'b0);
      else        cyc(1, 4'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL rr c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_gather();
    logic [3:0] s;
    do_reset(2);
    for (int c = 0; c < 100; c++) begin
      if (c == 0)     s = 4'b0100;
      else if (c < 5) s = 4'b0011;
      else            s = 4'($urandom_range(0, 7));
      cyc(2, s, (c < 8) ? 1'b1 : ($urandom_range(0, 3) != 0), 1'b0);
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL gather c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    for (int c = 0; c < 16; c++) begin
      cyc(1, 4'hF, c >= 5, 1'b0);
      checks++;
      if (obs_v !== exp_v || (c >= 2 && c < 5 && obs_v[15:12] !== 4'd0)) begin
        errors++;
        $display("FAIL backpressure c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    for (int c = 0; c < 11; c++) begin
      cyc(0, 4'b0001, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v || (c > 0 && mq.size() != 1)) begin
        errors++;
        $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    cyc(2, 4'b0011, 1'b0, 1'b0);
    cyc(2, 4'b0011, 1'b0, 1'b0);
    cyc(2, 4'b0111, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) begin
      cyc(2, 4'b0111, 1'b1, 1'b0);
      checks++;
      if (obs_v !== exp_v || (c == 0 && obs_v[11] !== 1'b0)) begin
        errors++;
        $display("FAIL reset_mid c=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    p_stb = '0; r_stb = '0; g_stb = '0;
    p_dat = '0; r_dat = '0; g_dat = '0;
    p_rrdy = 1'b1; r_rrdy = 1'b1; g_rrdy = 1'b1;
    m_ptr = 0;
    m_msk = '0;
    test_reset();
    test_pri();
    test_rr();
    test_gather();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
